display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner sharing one external hex-to-7-segment decoder.
// New values are staged and only committed at a frame boundary so a frame never tears.
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_en,
  input  logic [3:0]  blank_mask,
  output logic        load_ack,
  output logic [3:0]  nib_out,
  input  logic [0:6]  seg_in,
  output logic [0:6]  seg,
  output logic [3:0]  an
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_digit;
  logic [15:0] r_disp;
  logic [15:0] r_stage;
  logic        r_pending;
  logic        r_ack;
  logic [3:0]  r_an;
  logic [0:6]  r_seg;

  logic        w_blank_done;
  logic        w_drive_done;
  logic        w_frame_end;
  logic        w_drive_next;
  logic [3:0]  w_upper_nz;
  logic [3:0]  w_dark;

  assign w_blank_done = (r_state == BLANK) && (r_cnt == CW'(BLANK_CYC - 1));
  assign w_drive_done = (r_state == DRIVE) && (r_cnt == CW'(SCAN_DIV - 1));
  assign w_frame_end  = w_drive_done && (r_digit == 2'd3);
  assign w_drive_next = w_blank_done || ((r_state == DRIVE) && !w_drive_done);

  assign nib_out = r_disp[{r_digit, 2'b00} +: 4];

  // w_upper_nz[k]: some digit in k..3 is non-zero, so digit k is not a leading zero
  assign w_upper_nz[3] = |r_disp[15:12];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_nz
      assign w_upper_nz[gi] = w_upper_nz[gi+1] | (|r_disp[4*gi +: 4]);
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_dark
      if (gi == 0) begin : g_d0
        assign w_dark[gi] = blank_mask[gi];
      end else begin : g_dn
        assign w_dark[gi] = blank_mask[gi] | (lz_en & ~w_upper_nz[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= BLANK;
      r_cnt     <= '0;
      r_digit   <= 2'd0;
      r_disp    <= 16'h0000;
      r_stage   <= 16'h0000;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_an      <= 4'b1111;
      r_seg     <= 7'b1111111;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        BLANK: begin
          if (w_blank_done) begin
            r_state <= DRIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (w_drive_done) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_digit <= r_digit + 2'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= BLANK;
      endcase

      if (w_frame_end && r_pending) begin
        r_disp    <= r_stage;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end
      // A load on the boundary cycle wins the pending flag for the next frame
      if (load) begin
        r_stage   <= value;
        r_pending <= 1'b1;
      end

      // Outputs are computed from the upcoming state so they align with it exactly
      if (w_drive_next && !w_dark[r_digit]) begin
        r_an  <= ~(4'b0001 << r_digit);
        r_seg <= seg_in;
      end else begin
        r_an  <= 4'b1111;
        r_seg <= 7'b1111111;
      end
    end
  end

  assign load_ack = r_ack;
  assign an       = r_an;
  assign seg      = r_seg;

endmodule
